// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   // Response FSM: IDLE = nothing owed, RESP = a response is due this cycle.
   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   // Requester index.
   typedef logic port_t;

   localparam port_t PORT_IF  = 1'b0;   // instruction fetch
   localparam port_t PORT_LSU = 1'b1;   // load/store unit

   // The port that is not p.
   function automatic port_t other_port(input port_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_t      last_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   // Lone requester always wins; under contention the port that did not win last time wins.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (other_port(last_i) == PORT_LSU) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (IF / LSU) arbiter in front of a single-ported memory with
// one-cycle read latency. Grants are same-cycle; responses return one cycle
// after the grant to the port that owned it.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_WORDS  = 4096,
   parameter logic        RESET_LAST = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        p0_req_i,
   input  logic        p0_we_i,
   input  logic [3:0]  p0_be_i,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_wdata_i,
   output logic        p0_gnt_o,
   output logic        p0_rvalid_o,
   output logic [31:0] p0_rdata_o,

   input  logic        p1_req_i,
   input  logic        p1_we_i,
   input  logic [3:0]  p1_be_i,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   output logic        p1_gnt_o,
   output logic        p1_rvalid_o,
   output logic [31:0] p1_rdata_o,

   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ready_i,

   output logic        err_o
);

   // Byte-address limit; one bit wider so a 32-bit address never wraps the compare.
   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

   state_e     state_q, state_d;
   port_t      owner_q, owner_d;
   port_t      last_q,  last_d;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       any_gnt;
   port_t      gnt_port;

   assign req = {p1_req_i, p0_req_i};

   // Grants are suppressed while in reset so nothing reaches memory.
   rr_arb2 u_rr_arb2 (
      .req_i  (req),
      .last_i (last_q),
      .en_i   (mem_ready_i & rst_ni),
      .gnt_o  (gnt)
   );

   assign p0_gnt_o  = gnt[0];
   assign p1_gnt_o  = gnt[1];
   assign any_gnt   = |gnt;
   assign gnt_port  = gnt[1] ? PORT_LSU : PORT_IF;
   assign mem_req_o = p0_gnt_o | p1_gnt_o;

   // Forward the winning command to memory; an idle bus reads as all zeros.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b0000;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (gnt[0]) begin
         mem_we_o    = p0_we_i;
         mem_be_o    = p0_be_i;
         mem_addr_o  = p0_addr_i;
         mem_wdata_o = p0_wdata_i;
      end else if (gnt[1]) begin
         mem_we_o    = p1_we_i;
         mem_be_o    = p1_be_i;
         mem_addr_o  = p1_addr_i;
         mem_wdata_o = p1_wdata_i;
      end
   end

   // Out-of-range flag for the granted access; the access itself still goes out.
   assign err_o = mem_req_o && ({1'b0, mem_addr_o} >= ADDR_LIMIT);

   // State, response owner and round-robin history registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= PORT_IF;
         last_q  <= port_t'(RESET_LAST);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Next state, owner/history capture on grant, and rvalid routing to the owner.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      p0_rvalid_o = 1'b0;
      p1_rvalid_o = 1'b0;

      if (any_gnt) begin
         owner_d = gnt_port;
         last_d  = gnt_port;
      end

      unique case (state_q)
         IDLE: begin
            if (any_gnt) state_d = RESP;
         end
         RESP: begin
            p0_rvalid_o = (owner_q == PORT_IF);
            p1_rvalid_o = (owner_q == PORT_LSU);
            state_d     = any_gnt ? RESP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Response data is passed through untouched, only while valid.
   assign p0_rdata_o = p0_rvalid_o ? mem_rdata_i : 32'h0;
   assign p1_rdata_o = p1_rvalid_o ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory model drives mem_rdata_i, and a word-level
// reference model predicts grants, memory command, err and responses each cycle.
module tb_mem_arbiter;

   localparam int unsigned MEM_WORDS = 4096;
   localparam logic [31:0] LIMIT     = 32'(4 * MEM_WORDS);

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
   logic [3:0]  p0_be_i, p1_be_i;
   logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
   logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
   logic [31:0] p0_rdata_o, p1_rdata_o;
   logic        mem_req_o, mem_we_o, mem_ready_i, err_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.MEM_WORDS(MEM_WORDS), .RESET_LAST(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
      .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
      .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
      .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
      .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
      .err_o(err_o)
   );

   // Memory: unwritten word i reads {C0DE, i}; writes answer fa111eaf, out of range deadbeef.
   bit [31:0] env_mem [MEM_WORDS];
   bit        env_wr  [MEM_WORDS];

   always @(posedge clk_i) begin
      if (mem_req_o) begin
         if (mem_addr_o >= LIMIT) begin
            mem_rdata_i <= 32'hdeadbeef;
         end else begin
            logic [31:0] cur;
            cur = env_wr[mem_addr_o[13:2]] ? env_mem[mem_addr_o[13:2]]
                                           : {16'hC0DE, 4'h0, mem_addr_o[13:2]};
            if (mem_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be_o[b]) cur[8*b +: 8] = mem_wdata_o[8*b +: 8];
               env_mem[mem_addr_o[13:2]] <= cur;
               env_wr[mem_addr_o[13:2]]  <= 1'b1;
               mem_rdata_i <= 32'hfa111eaf;
            end else begin
               mem_rdata_i <= cur;
            end
         end
      end
   end

   // Reference model state.
   logic [31:0] ref_mem [MEM_WORDS];
   int          m_last;
   bit          m_pend;
   int          m_pend_port;
   logic [31:0] m_pend_data;
   int          m_winner;

   function automatic logic [31:0] ref_access(input logic we, input logic [3:0] be,
                                              input logic [31:0] a, input logic [31:0] wd);
      if (a >= LIMIT) return 32'hdeadbeef;
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[13:2]][8*b +: 8] = wd[8*b +: 8];
         return 32'hfa111eaf;
      end
      return ref_mem[a[13:2]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Let inputs settle, compare every output with the model, then advance the model past the next edge.
   task automatic settle();
      int          w;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wd;
      bit          r0, r1;
      #1;
      w = -1;
      if (rst_ni && mem_ready_i) begin
         if (p0_req_i && p1_req_i) w = 1 - m_last;
         else if (p0_req_i)        w = 0;
         else if (p1_req_i)        w = 1;
      end
      e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
      if (w == 0) begin e_we = p0_we_i; e_be = p0_be_i; e_addr = p0_addr_i; e_wd = p0_wdata_i; end
      if (w == 1) begin e_we = p1_we_i; e_be = p1_be_i; e_addr = p1_addr_i; e_wd = p1_wdata_i; end

      chk("p0_gnt",    32'(p0_gnt_o),  32'(w == 0));
      chk("p1_gnt",    32'(p1_gnt_o),  32'(w == 1));
      chk("mem_req",   32'(mem_req_o), 32'(w >= 0));
      chk("mem_we",    32'(mem_we_o),  32'(e_we));
      chk("mem_be",    32'(mem_be_o),  32'(e_be));
      chk("mem_addr",  mem_addr_o,     e_addr);
      chk("mem_wdata", mem_wdata_o,    e_wd);
      chk("err",       32'(err_o),     32'(w >= 0 && e_addr >= LIMIT));

      r0 = rst_ni && m_pend && (m_pend_port == 0);
      r1 = rst_ni && m_pend && (m_pend_port == 1);
      chk("p0_rvalid", 32'(p0_rvalid_o), 32'(r0));
      chk("p1_rvalid", 32'(p1_rvalid_o), 32'(r1));
      chk("p0_rdata",  p0_rdata_o, r0 ? m_pend_data : 32'h0);
      chk("p1_rdata",  p1_rdata_o, r1 ? m_pend_data : 32'h0);

      if (w >= 0)
         $display("txn t=%0t port=%0d we=%0b be=%h addr=%h wdata=%h", $time, w, e_we, e_be, e_addr, e_wd);

      if (!rst_ni) begin
         m_pend = 0;
         m_last = 1;
      end else begin
         m_pend = (w >= 0);
         if (w >= 0) begin
            m_last      = w;
            m_pend_port = w;
            m_pend_data = ref_access(e_we, e_be, e_addr, e_wd);
         end
      end
      m_winner = w;
   endtask

   task automatic cyc();
      settle();
      @(negedge clk_i);
   endtask

   initial begin
      for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = {16'hC0DE, 16'(i)};
      m_last = 1; m_pend = 0; m_pend_port = 0; m_pend_data = 32'h0; m_winner = -1;
      rst_ni = 1'b0; mem_ready_i = 1'b1;
      p0_req_i = 0; p0_we_i = 0; p0_be_i = 4'hF; p0_addr_i = 0; p0_wdata_i = 0;
      p1_req_i = 0; p1_we_i = 0; p1_be_i = 4'hF; p1_addr_i = 0; p1_wdata_i = 0;
      @(negedge clk_i);

      // In reset with both requesting: nothing granted, nothing returned.
      p0_req_i = 1; p1_req_i = 1;
      cyc();
      p0_req_i = 0; p1_req_i = 0;
      rst_ni = 1'b1;

      // Lone p0 read of 0x10, granted in the first cycle out of reset.
      p0_req_i = 1; p0_we_i = 0; p0_addr_i = 32'h10;
      settle();
      chk("t1_gnt",  32'(p0_gnt_o), 32'd1);
      chk("t1_addr", mem_addr_o, 32'h10);
      @(negedge clk_i);
      p0_req_i = 0;
      settle();
      chk("t1_rdata", p0_rdata_o, 32'hC0DE0004);
      @(negedge clk_i);

      // Back-to-back contention from reset: p0,p1,p0,p1.
      rst_ni = 1'b0;
      cyc();
      rst_ni = 1'b1;
      p0_req_i = 1; p0_addr_i = 32'h20; p1_req_i = 1; p1_we_i = 0; p1_addr_i = 32'h24;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("t2_p0_gnt", 32'(p0_gnt_o), 32'((k % 2) == 0));
         @(negedge clk_i);
      end

      // Memory stalled for 3 cycles; then the port after p1 (p0) wins.
      mem_ready_i = 1'b0;
      repeat (3) cyc();
      mem_ready_i = 1'b1;
      settle();
      chk("t4_p0_gnt", 32'(p0_gnt_o), 32'd1);
      @(negedge clk_i);
      p0_req_i = 0; p1_req_i = 0;
      cyc();

      // p1 byte write then p0 read-back.
      p1_req_i = 1; p1_we_i = 1; p1_be_i = 4'b0010; p1_addr_i = 32'h8; p1_wdata_i = 32'hAABBCCDD;
      cyc();
      p1_req_i = 0;
      p0_req_i = 1; p0_we_i = 0; p0_addr_i = 32'h8;
      settle();
      chk("t3_wr_ack", p1_rdata_o, 32'hfa111eaf);
      @(negedge clk_i);
      p0_req_i = 0;
      settle();
      chk("t3_rdata", p0_rdata_o, 32'hC0DECC02);
      @(negedge clk_i);

      // Out-of-range read.
      p0_req_i = 1; p0_addr_i = 32'h4000;
      settle();
      chk("t5_err", 32'(err_o), 32'd1);
      @(negedge clk_i);
      p0_req_i = 0;
      settle();
      chk("t5_rdata", p0_rdata_o, 32'hdeadbeef);
      @(negedge clk_i);

      // Reset right after a p0 grant drops the response; p0 still wins afterwards.
      p0_req_i = 1; p0_addr_i = 32'h0;
      cyc();
      p0_req_i = 0; rst_ni = 1'b0;
      settle();
      chk("t6_rvalid", 32'(p0_rvalid_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      p0_req_i = 1; p1_req_i = 1; p1_we_i = 0; p1_addr_i = 32'h4;
      settle();
      chk("t6_p0_gnt", 32'(p0_gnt_o), 32'd1);
      @(negedge clk_i);
      p0_req_i = 0; p1_req_i = 0;
      cyc();
      m_winner = -1;

      // Random traffic: requesters hold commands until granted; stalls and rare resets.
      for (int c = 0; c < 400; c++) begin
         if (m_winner == 0) p0_req_i = 0;
         if (m_winner == 1) p1_req_i = 0;
         if (!p0_req_i && $urandom_range(0, 2) != 0) begin
            p0_req_i   = 1;
            p0_we_i    = 1'($urandom_range(0, 1));
            p0_be_i    = 4'($urandom_range(0, 15));
            p0_addr_i  = ($urandom_range(0, 9) == 0) ? 32'h4000 + $urandom_range(0, 255)
                                                     : 32'($urandom_range(0, 127));
            p0_wdata_i = $urandom;
         end
         if (!p1_req_i && $urandom_range(0, 2) != 0) begin
            p1_req_i   = 1;
            p1_we_i    = 1'($urandom_range(0, 1));
            p1_be_i    = 4'($urandom_range(0, 15));
            p1_addr_i  = ($urandom_range(0, 9) == 0) ? 32'h4000 + $urandom_range(0, 255)
                                                     : 32'($urandom_range(0, 127));
            p1_wdata_i = $urandom;
         end
         mem_ready_i = ($urandom_range(0, 4) != 0);
         rst_ni      = ($urandom_range(0, 63) != 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
